// File: rtl/game_session_mux.sv
// game_session_mux: session FSM, rating counter and strip compositor for
// NUM_GAMES side-by-side game lanes driving one registered VGA pixel.
module game_session_mux #(
    parameter  int NUM_GAMES        = 2,
    parameter  int SCREEN_WIDTH     = 800,
    parameter  int SCREEN_HEIGHT    = 600,
    parameter  int RATING_WIDTH     = 8,
    parameter  int COUNTDOWN_CYCLES = 100,
    parameter  int WIN_ALL          = 0,
    localparam int STRIP_W          = SCREEN_WIDTH / NUM_GAMES,
    localparam int X_W              = $clog2(STRIP_W),
    localparam int SEL_W            = (NUM_GAMES > 1) ? $clog2(NUM_GAMES) : 1
) (
    input  logic                      clk,
    input  logic                      arst_n,
    input  logic [NUM_GAMES-1:0]      i_lane_enable,
    input  logic                      i_start,
    input  logic                      i_pause,
    input  logic [NUM_GAMES-1:0]      i_lane_win,
    input  logic [NUM_GAMES-1:0]      i_lane_lose,
    input  logic [NUM_GAMES-1:0]      i_lane_ready,
    input  logic [10:0]               i_h_coord,
    input  logic [9:0]                i_v_coord,
    input  logic                      i_disp_enbl,
    input  logic [12*NUM_GAMES-1:0]   i_lane_rgb,
    input  logic [11:0]               i_banner_rgb,
    output logic [X_W-1:0]            o_local_x,
    output logic [9:0]                o_local_y,
    output logic [SEL_W-1:0]          o_lane_sel,
    output logic [11:0]               o_rgb,
    output logic                      o_disp_enbl,
    output logic                      o_regenerate_level,
    output logic                      o_game_running,
    output logic [1:0]                o_banner_num,
    output logic [RATING_WIDTH-1:0]   o_rating,
    output logic [2*NUM_GAMES-1:0]    o_lane_result
);

    // Elaboration-time sanity checks on the geometry and lane count.
    if (NUM_GAMES < 1 || NUM_GAMES > 4) begin : g_bad_lanes
        $error("game_session_mux: NUM_GAMES must be 1..4");
    end
    if (SCREEN_WIDTH % NUM_GAMES != 0) begin : g_bad_width
        $error("game_session_mux: SCREEN_WIDTH must divide evenly into strips");
    end
    if (SCREEN_HEIGHT < 1 || SCREEN_HEIGHT > 1024) begin : g_bad_height
        $error("game_session_mux: SCREEN_HEIGHT must fit the 10-bit v coordinate");
    end
    if (COUNTDOWN_CYCLES < 1) begin : g_bad_countdown
        $error("game_session_mux: COUNTDOWN_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_COUNTDOWN, S_RUN, S_PAUSED, S_WIN, S_LOSE
    } state_t;

    localparam int               CNT_W    = (COUNTDOWN_CYCLES > 1) ? $clog2(COUNTDOWN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COUNTDOWN_CYCLES - 1);

    state_t               state;
    logic                 start_q;
    logic [NUM_GAMES-1:0] mask;
    logic [CNT_W-1:0]     cnt;

    logic                   start_edge;
    logic                   all_ready;
    logic                   lose_hit;
    logic                   win_hit;
    logic [NUM_GAMES-1:0]   acc_win;
    logic [2*NUM_GAMES-1:0] lane_acc;

    assign start_edge = i_start & ~start_q;
    assign all_ready  = ((i_lane_ready & mask) == mask);
    assign lose_hit   = |(i_lane_lose & mask);
    // WIN_ALL counts wins already latched this session plus this cycle's wins.
    assign win_hit    = (WIN_ALL != 0) ? (((acc_win | i_lane_win) & mask) == mask)
                                       : |(i_lane_win & mask);

    // Per-lane {win,lose} accumulation, restricted to lanes in the session mask.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        acc_win  = '0;
        lane_acc = '0;
        for (int k = 0; k < NUM_GAMES; k++) begin
            acc_win[k]        = o_lane_result[2*k+1];
            lane_acc[2*k+1]   = o_lane_result[2*k+1] | (i_lane_win[k]  & mask[k]);
            lane_acc[2*k]     = o_lane_result[2*k]   | (i_lane_lose[k] & mask[k]);
        end
    end

    // Session FSM with registered status outputs, rating and lane results.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state              <= S_IDLE;
            start_q            <= 1'b0;
            mask               <= '0;
            cnt                <= '0;
            o_regenerate_level <= 1'b0;
            o_game_running     <= 1'b0;
            o_banner_num       <= 2'd0;
            o_rating           <= '0;
            o_lane_result      <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
            start_q            <= i_start;
            o_regenerate_level <= 1'b0;
            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_edge && (|i_lane_enable)) begin
                        state              <= S_GEN;
                        mask               <= i_lane_enable;
                        o_lane_result      <= '0;
                        o_regenerate_level <= 1'b1;
                        o_banner_num       <= 2'd0;
                    end
                end
                S_GEN: begin
                    // Ready flags are trusted only after the regenerate pulse has gone out.
                    if (!o_regenerate_level && all_ready) begin
                        state <= S_COUNTDOWN;
                        cnt   <= CNT_LOAD;
                    end
                end
                S_COUNTDOWN: begin
                    if (cnt == '0) begin
                        state          <= S_RUN;
                        o_game_running <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    o_lane_result <= lane_acc;
                    if (i_pause) begin
                        state          <= S_PAUSED;
                        o_game_running <= 1'b0;
                        o_banner_num   <= 2'd3;
                    end else if (lose_hit) begin
                        state          <= S_LOSE;
                        o_game_running <= 1'b0;
                        o_banner_num   <= 2'd2;
                        o_rating       <= '0;
                    end else if (win_hit) begin
                        state          <= S_WIN;
                        o_game_running <= 1'b0;
                        o_banner_num   <= 2'd1;
                        if (o_rating != '1) o_rating <= o_rating + 1'b1;
                    end
                end
                S_PAUSED: begin
                    if (!i_pause) begin
                        state          <= S_RUN;
                        o_game_running <= 1'b1;
                        o_banner_num   <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strip decode by threshold comparison, plus the selected lane's colour and mask bit.
    logic [10:0]      base;
    logic [SEL_W-1:0] lane_idx;
    logic             on_screen;
    logic [11:0]      lane_colour;
    logic             lane_on;

    assign on_screen = (i_h_coord < 11'(SCREEN_WIDTH));

    always_comb begin
        lane_idx    = '0;
        base        = '0;
        lane_colour = '0;
        lane_on     = 1'b0;
        for (int k = 1; k < NUM_GAMES; k++) begin
            if (i_h_coord >= 11'(k * STRIP_W)) begin
                lane_idx = SEL_W'(k);
                base     = 11'(k * STRIP_W);
            end
        end
        if (!on_screen) begin
            lane_idx = '0;
            base     = i_h_coord;
        end
        for (int k = 0; k < NUM_GAMES; k++) begin
            if (lane_idx == SEL_W'(k)) begin
                lane_colour = i_lane_rgb[12*k +: 12];
                lane_on     = mask[k];
            end
        end
    end

    assign o_local_x  = X_W'(i_h_coord - base);
    assign o_local_y  = i_v_coord;
    assign o_lane_sel = lane_idx;

    // Registered pixel: blanking, then banner outside RUN, then masked lane colour.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_rgb       <= '0;
            o_disp_enbl <= 1'b0;
        end else begin
            o_disp_enbl <= i_disp_enbl;
            if (!i_disp_enbl || !on_screen) o_rgb <= '0;
            else if (state != S_RUN)        o_rgb <= i_banner_rgb;
            else if (!lane_on)              o_rgb <= '0;
            else                            o_rgb <= lane_colour;
        end
    end

endmodule

// File: tb/tb_game_session_mux.sv
// Directed bench for game_session_mux: unit 0 uses defaults (WIN_ALL=0),
// unit 1 uses WIN_ALL=1 with a short countdown and 2-bit rating.
module tb_game_session_mux;

    logic clk;
    logic arst_n;

    logic [1:0]       start, pause;
    logic [1:0][1:0]  en, win, lose, ready;
    logic [10:0]      h;
    logic [9:0]       v;
    logic             disp;
    logic [23:0]      lane_rgb;
    logic [11:0]      banner_rgb;

    logic [1:0][8:0]  lx;
    logic [1:0][9:0]  ly;
    logic [1:0]       lane_sel;
    logic [1:0][11:0] rgb_o;
    logic [1:0]       disp_o, regen, running;
    logic [1:0][1:0]  banner;
    logic [1:0][3:0]  lane_res;
    logic [7:0]       rating_a;
    logic [1:0]       rating_b;

    int n_checks = 0;
    int n_fail   = 0;

    game_session_mux dut (
        .clk(clk), .arst_n(arst_n),
        .i_lane_enable(en[0]), .i_start(start[0]), .i_pause(pause[0]),
        .i_lane_win(win[0]), .i_lane_lose(lose[0]), .i_lane_ready(ready[0]),
        .i_h_coord(h), .i_v_coord(v), .i_disp_enbl(disp),
        .i_lane_rgb(lane_rgb), .i_banner_rgb(banner_rgb),
        .o_local_x(lx[0]), .o_local_y(ly[0]), .o_lane_sel(lane_sel[0]),
        .o_rgb(rgb_o[0]), .o_disp_enbl(disp_o[0]),
        .o_regenerate_level(regen[0]), .o_game_running(running[0]),
        .o_banner_num(banner[0]), .o_rating(rating_a), .o_lane_result(lane_res[0])
    );

    game_session_mux #(.RATING_WIDTH(2), .COUNTDOWN_CYCLES(4), .WIN_ALL(1)) dut_all (
        .clk(clk), .arst_n(arst_n),
        .i_lane_enable(en[1]), .i_start(start[1]), .i_pause(pause[1]),
        .i_lane_win(win[1]), .i_lane_lose(lose[1]), .i_lane_ready(ready[1]),
        .i_h_coord(h), .i_v_coord(v), .i_disp_enbl(disp),
        .i_lane_rgb(lane_rgb), .i_banner_rgb(banner_rgb),
        .o_local_x(lx[1]), .o_local_y(ly[1]), .o_lane_sel(lane_sel[1]),
        .o_rgb(rgb_o[1]), .o_disp_enbl(disp_o[1]),
        .o_regenerate_level(regen[1]), .o_game_running(running[1]),
        .o_banner_num(banner[1]), .o_rating(rating_b), .o_lane_result(lane_res[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a session on unit u and walk it through GEN and COUNTDOWN into RUN.
    task automatic start_session(input int u, input logic [1:0] mask, input int cd);
        en[u]    = mask;
        ready[u] = 2'b00;
        start[u] = 1'b1;
        tick();
        check("gen_pulse_high", regen[u], 1);
        check("gen_result_clear", lane_res[u], 0);
        check("gen_banner", banner[u], 0);
        check("gen_not_running", running[u], 0);
        start[u] = 1'b0;
        tick();
        check("gen_pulse_one_cycle", regen[u], 0);
        repeat (3) tick();
        ready[u] = mask;
        tick();
        repeat (cd - 1) tick();
        check("countdown_not_running", running[u], 0);
        check("countdown_banner", banner[u], 0);
        tick();
        check("countdown_done_running", running[u], 1);
    endtask

    typedef struct packed {
        logic [10:0] h;
        logic        disp;
        logic        lane;
        logic [8:0]  x;
        logic [11:0] rgb;
    } pix_t;

    pix_t vec [8];

    initial begin
        // Pixel vectors, applied while unit 0 runs with mask 2'b01 (lane 1 disabled).
        vec[0] = '{h: 11'd0,    disp: 1'b1, lane: 1'b0, x: 9'd0,   rgb: 12'hA11};
        vec[1] = '{h: 11'd399,  disp: 1'b1, lane: 1'b0, x: 9'd399, rgb: 12'hA11};
        vec[2] = '{h: 11'd400,  disp: 1'b1, lane: 1'b1, x: 9'd0,   rgb: 12'h000};
        vec[3] = '{h: 11'd799,  disp: 1'b1, lane: 1'b1, x: 9'd399, rgb: 12'h000};
        vec[4] = '{h: 11'd800,  disp: 1'b1, lane: 1'b0, x: 9'd0,   rgb: 12'h000};
        vec[5] = '{h: 11'd1000, disp: 1'b1, lane: 1'b0, x: 9'd0,   rgb: 12'h000};
        vec[6] = '{h: 11'd200,  disp: 1'b0, lane: 1'b0, x: 9'd200, rgb: 12'h000};
        vec[7] = '{h: 11'd123,  disp: 1'b1, lane: 1'b0, x: 9'd123, rgb: 12'hA11};

        arst_n = 1'b0;
        start = '0; pause = '0; en = '0; win = '0; lose = '0; ready = '0;
        h = '0; v = '0; disp = 1'b0;
        lane_rgb   = 24'hB22_A11;
        banner_rgb = 12'h5C5;

        // Reset state.
        #12;
        check("rst_rgb", rgb_o[0], 0);
        check("rst_disp", disp_o[0], 0);
        check("rst_regen", regen[0], 0);
        check("rst_running", running[0], 0);
        check("rst_banner", banner[0], 0);
        check("rst_rating", rating_a, 0);
        check("rst_result", lane_res[0], 0);
        arst_n = 1'b1;

        // Banner shown while idle.
        h = 11'd10; disp = 1'b1;
        tick();
        check("idle_banner_rgb", rgb_o[0], 12'h5C5);
        check("idle_disp_out", disp_o[0], 1);
        disp = 1'b0;

        // Start with an empty mask is ignored.
        en[0] = 2'b00; start[0] = 1'b1;
        tick();
        check("mask0_no_pulse", regen[0], 0);
        start[0] = 1'b0;
        tick();
        check("mask0_no_pulse_later", regen[0], 0);

        // Session A: both lanes, lane 0 wins.
        start_session(0, 2'b11, 100);
        h = 11'd400; disp = 1'b1;
        tick();
        check("run_lane1_rgb", rgb_o[0], 12'hB22);
        h = 11'd100;
        tick();
        check("run_lane0_rgb", rgb_o[0], 12'hA11);
        disp = 1'b0;
        win[0] = 2'b01;
        tick();
        win[0] = 2'b00;
        check("win_banner", banner[0], 1);
        check("win_not_running", running[0], 0);
        check("win_rating", rating_a, 1);
        check("win_result", lane_res[0], 4'b0010);
        tick();
        check("win_rating_hold", rating_a, 1);

        // Session B: pause masks a lose, then lose beats win.
        start_session(0, 2'b11, 100);
        pause[0] = 1'b1;
        tick();
        check("pause_banner", banner[0], 3);
        check("pause_not_running", running[0], 0);
        lose[0] = 2'b11;
        tick();
        check("pause_ignores_lose", banner[0], 3);
        check("pause_result_hold", lane_res[0], 0);
        lose[0] = 2'b00; pause[0] = 1'b0;
        tick();
        check("resume_running", running[0], 1);
        check("resume_banner", banner[0], 0);
        win[0] = 2'b01; lose[0] = 2'b10;
        tick();
        win[0] = 2'b00; lose[0] = 2'b00;
        check("lose_banner", banner[0], 2);
        check("lose_rating_clear", rating_a, 0);
        check("lose_result", lane_res[0], 4'b0110);
        check("lose_not_running", running[0], 0);

        // Session C: lane 0 only; lane 1 status ignored, lane 1 strip black.
        start_session(0, 2'b01, 100);
        lose[0] = 2'b10;
        tick();
        check("unlatched_lose_ignored", running[0], 1);
        lose[0] = 2'b00; win[0] = 2'b10;
        tick();
        check("unlatched_win_ignored", running[0], 1);
        win[0] = 2'b00;
        for (int i = 0; i < 8; i++) begin
            h = vec[i].h; v = 10'(i * 37 + 3); disp = vec[i].disp;
            #1;
            check("pix_lane", lane_sel[0], vec[i].lane);
            check("pix_x", lx[0], vec[i].x);
            check("pix_y", ly[0], 10'(i * 37 + 3));
            if (i > 0) check("pix_rgb_lag", rgb_o[0], vec[i-1].rgb);
            tick();
            check("pix_rgb", rgb_o[0], vec[i].rgb);
            check("pix_disp", disp_o[0], vec[i].disp);
        end
        disp = 1'b0;
        win[0] = 2'b01;
        tick();
        win[0] = 2'b00;
        check("c_win_banner", banner[0], 1);
        check("c_win_rating", rating_a, 1);
        check("c_win_result_masked", lane_res[0], 4'b0010);

        // WIN_ALL unit: lane 0 wins at t, lane 1 at t+20.
        start_session(1, 2'b11, 4);
        win[1] = 2'b01;
        tick();
        win[1] = 2'b00;
        check("all_partial_running", running[1], 1);
        repeat (19) tick();
        check("all_partial_still_running", running[1], 1);
        win[1] = 2'b10;
        tick();
        win[1] = 2'b00;
        check("all_win_banner", banner[1], 1);
        check("all_win_rating", rating_b, 1);
        check("all_win_result", lane_res[1], 4'b1010);
        for (int s = 2; s <= 4; s++) begin
            start_session(1, 2'b11, 4);
            win[1] = 2'b11;
            tick();
            win[1] = 2'b00;
            check("all_sat_banner", banner[1], 1);
            check("all_sat_rating", rating_b, (s > 3) ? 3 : s);
        end

        // Reset mid-countdown on unit 0.
        h = 11'd10; disp = 1'b1;
        en[0] = 2'b11; ready[0] = 2'b11; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        repeat (11) tick();
        check("pre_reset_banner_rgb", rgb_o[0], 12'h5C5);
        #2;
        arst_n = 1'b0;
        #1;
        check("midrst_rgb", rgb_o[0], 0);
        check("midrst_disp", disp_o[0], 0);
        check("midrst_rating", rating_a, 0);
        check("midrst_banner", banner[0], 0);
        check("midrst_running", running[0], 0);
        check("midrst_regen", regen[0], 0);
        check("midrst_result_b", lane_res[1], 0);
        check("midrst_rating_b", rating_b, 0);
        check("midrst_banner_b", banner[1], 0);
        #3;
        arst_n = 1'b1;
        disp = 1'b0;
        tick();
        check("post_rst_idle_running", running[0], 0);
        check("post_rst_idle_regen", regen[0], 0);
        start_session(0, 2'b11, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_session_mux.md
# game_session_mux

Parametrised session controller and screen compositor for the game console: it runs NUM_GAMES independent game lanes side by side in equal vertical strips. It owns the session state machine (idle, level generation, countdown, run, pause, win, lose), and aggregates per-lane win/lose/ready flags. It keeps the saturating rating counter and drives one registered VGA pixel, choosing between lane colours and the banner image. It sits between the per-lane game engines/graphics blocks and the top-level monitor, quad-display and LED outputs.

## Interface
- NUM_GAMES, 2: number of lanes (1..4); strip width W = SCREEN_WIDTH/NUM_GAMES, integer.
- SCREEN_WIDTH, 800: visible pixels per line.
- SCREEN_HEIGHT, 600: visible lines.
- RATING_WIDTH, 8: rating counter width.
- COUNTDOWN_CYCLES, 100: cycles spent in COUNTDOWN, ≥1.
- WIN_ALL, 0: 0 = any enabled lane win wins the session; 1 = every enabled lane must have won.
- clk  in  1  system clock; the block uses this one clock only.
- arst_n  in  1  reset, asynchronous assert, active-low.
- i_lane_enable  in  NUM_GAMES  lane participation mask, sampled on entry to GEN.
- i_start  in  1  start button level; the block acts on its rising edge only.
- i_pause  in  1  pause level.
- i_lane_win / i_lane_lose / i_lane_ready  in  NUM_GAMES each  per-lane status from the engines.
- i_h_coord  in  11  / i_v_coord  in  10  / i_disp_enbl  in  1  monitor scan position and enable.
- i_lane_rgb  in  12*NUM_GAMES  lane colour, {r,g,b}, lane k at bits [12k+11:12k].
- i_banner_rgb  in  12  banner colour.
- o_local_x  out  $clog2(W)  x within the current strip (combinational).
- o_local_y  out  10  equal to i_v_coord.
- o_lane_sel  out  $clog2(NUM_GAMES) min 1  index of the current strip.
- o_rgb  out  12  registered pixel; reset 0.
- o_disp_enbl  out  1  i_disp_enbl delayed 1 cycle; reset 0.
- o_regenerate_level  out  1  1-cycle pulse; reset 0.
- o_game_running  out  1  high in RUN only; reset 0.
- o_banner_num  out  2  0 idle/gen/countdown, 1 win, 2 lose, 3 paused; reset 0.
- o_rating  out  RATING_WIDTH  reset 0.
- o_lane_result  out  2*NUM_GAMES  latched {win,lose} per lane; reset 0.

## Operation
- States: IDLE, GEN, COUNTDOWN, RUN, PAUSED, WIN, LOSE; reset → IDLE.
- IDLE/WIN/LOSE → GEN on a start edge if i_lane_enable ≠ 0. The start edge is ignored when the mask is 0. Entering GEN does the following:
  - latches the mask;
  - clears o_lane_result;
  - pulses o_regenerate_level for 1 cycle.
- GEN → COUNTDOWN when every latched lane has i_lane_ready = 1. This is evaluated from the cycle after the pulse onward.
- COUNTDOWN runs a counter from COUNTDOWN_CYCLES−1 down to 0, then moves to RUN.
- RUN behaviour:
  - i_pause → PAUSED.
  - Otherwise, lose on any latched lane → LOSE.
  - Otherwise, the win condition → WIN.
  - Lose has priority over win in the same cycle, and pause has priority over both.
- PAUSED → RUN when i_pause drops. Lane status is ignored while paused.
- Lane results: in RUN, o_lane_result bits for latched lanes are OR-accumulated from i_lane_win/i_lane_lose. The WIN_ALL=1 condition uses these accumulated win bits together with the current cycle's wins.
- Rating: on WIN entry, +1, saturating at all-ones. On LOSE entry, cleared to 0.
- Compositing:
  - lane = i_h_coord / W, computed by comparison (no divider).
  - o_local_x = i_h_coord − lane*W.
  - For i_h_coord ≥ SCREEN_WIDTH, lane and local_x are 0.
- Next o_rgb, in priority order:
  - 0 if i_disp_enbl = 0 or i_h_coord ≥ SCREEN_WIDTH;
  - else i_banner_rgb if state ≠ RUN;
  - else 0 if the lane is not in the latched mask;
  - else that lane's i_lane_rgb.

## Timing
- Pixel path: the coordinate outputs are combinational from i_h/i_v. Lane colour is expected back combinationally in the same cycle. o_rgb and o_disp_enbl appear 1 cycle later.
- Start edge: the previous i_start is registered. The edge is detected in cycle n; the state is GEN in n+1, with o_regenerate_level high in n+1 only.
- Status outputs (o_game_running, o_banner_num) are registered decodes of the state and change in the cycle the state changes.
- Reset mid-session: all outputs return to their reset values asynchronously, and the countdown and mask are cleared.

## Test plan
- NUM_GAMES=2, start edge with mask=2'b11 → o_regenerate_level high for exactly 1 cycle. Lanes ready 5 cycles later → COUNTDOWN lasts 100 cycles → o_game_running=1.
- RUN with i_lane_win=01 and i_lane_lose=10 in the same cycle → LOSE, o_banner_num=2, o_rating=0, o_lane_result=4'b0110.
- WIN_ALL=1: lane0 wins at cycle t and lane1 wins at t+20 → WIN entered only after t+20. Rating 255 → stays 255.
- Pause during RUN → o_banner_num=3 and lose is ignored. Release → RUN resumes.
- Pixel scan, h=399 → lane 0, x=399. h=400 → lane 1, x=0. h=800 → o_rgb=0. Disabled lane 1 → black; each o_rgb lags its coordinate by 1 cycle.
- Start with mask=0 → stays IDLE. arst_n pulse mid-COUNTDOWN → IDLE with all outputs 0.
